tmds_channel_decoder: RTL and testbench

- Receive-side counterpart of the DVI TMDS encoder/serializer path: consumes unaligned 10-bit words from a 10:1 deserializer, one per clock.
- Finds symbol alignment by hunting for runs of control tokens, then decodes each aligned symbol to DE, C1:C0 and an 8-bit pixel byte.
- One instance per TMDS channel (0/1/2), in the pixel clock domain, feeding a future DVI sink/capture path.

---
 rtl/tmds_channel_decoder.sv | 127 ++++++++++++
 tb/tb_tmds_channel_decoder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_channel_decoder.sv
// tmds_channel_decoder: aligns a raw 10-bit TMDS stream on control-token runs and decodes DE/C1:C0/pixel byte.
// Define TMDS_LOSS_CNT_EN to add the saturating loss_cnt output.
module tmds_channel_decoder #(
  parameter int CTRL_RUN      = 8,
  parameter int SEARCH_WINDOW = 64,
  parameter int LOCK_TIMEOUT  = 4096
) (
  input  logic       ref_clk,
  input  logic       rst_n,
  input  logic [9:0] raw_word,
  output logic       de,
  output logic [1:0] ctrl,
  output logic [7:0] data,
  output logic       locked,
  output logic [3:0] slip_offset
`ifdef TMDS_LOSS_CNT_EN
  ,
  output logic [15:0] loss_cnt
`endif
);
  localparam int WW = $clog2(SEARCH_WINDOW);
  localparam int IW = $clog2(LOCK_TIMEOUT + 1);
  typedef enum logic {SEARCH, LOCKED} state_t;
  state_t state_q, state_d;
  logic [9:0] prev_word_q, sym, sym_q;
  logic [19:0] hist;
  logic [7:0] run_cnt_q, run_cnt_d, run_inc;
  logic [WW-1:0] win_cnt_q, win_cnt_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d, idle_inc;
  logic [3:0] slip_q, slip_d;
  logic de_q, de_d, tok, tok_q;
  logic [1:0] ctrl_q, ctrl_d;
  logic [7:0] data_q, data_d, t, dec;

  function automatic logic is_tok(input logic [9:0] s);
    return s == 10'h354 || s == 10'h0AB || s == 10'h154 || s == 10'h2AB;
  endfunction

  function automatic logic [1:0] tok_val(input logic [9:0] s);
    return s == 10'h354 ? 2'd0 : s == 10'h0AB ? 2'd1 : s == 10'h154 ? 2'd2 : 2'd3;
  endfunction

  assign hist = {raw_word, prev_word_q};
  assign sym = hist[slip_q +: 10];
  assign tok = is_tok(sym);
  assign tok_q = is_tok(sym_q);
  assign t = sym_q[9] ? ~sym_q[7:0] : sym_q[7:0];
  assign dec = {sym_q[8] ? t[7:1] ^ t[6:0] : ~(t[7:1] ^ t[6:0]), t[0]};
  assign run_inc = run_cnt_q + {7'd0, run_cnt_q != 8'hFF};
  assign idle_inc = idle_cnt_q + IW'(idle_cnt_q != '1);
  assign locked = state_q == LOCKED;

  always_comb begin
    state_d = state_q;
    slip_d = slip_q;
    run_cnt_d = '0;
    win_cnt_d = '0;
    idle_cnt_d = '0;
    if (state_q == SEARCH) begin
      run_cnt_d = tok ? run_inc : '0;
      win_cnt_d = win_cnt_q + 1'b1;
      // lock wins over a slip landing on the same cycle
      if (tok && run_inc == 8'(CTRL_RUN)) begin
        state_d = LOCKED;
        run_cnt_d = '0;
        win_cnt_d = '0;
      end else if (win_cnt_q == WW'(SEARCH_WINDOW - 1)) begin
        slip_d = slip_q == 4'd9 ? 4'd0 : slip_q + 4'd1;
        run_cnt_d = '0;
        win_cnt_d = '0;
      end
    end else begin
      idle_cnt_d = tok ? '0 : idle_inc;
      if (idle_cnt_d == IW'(LOCK_TIMEOUT)) begin
        state_d = SEARCH;
        idle_cnt_d = '0;
      end
    end
  end

  always_comb begin
    de_d = locked && !tok_q;
    data_d = de_d ? dec : '0;
    ctrl_d = !locked ? 2'd0 : tok_q ? tok_val(sym_q) : ctrl_q;
  end

  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEARCH;
      prev_word_q <= '0;
      sym_q <= '0;
      run_cnt_q <= '0;
      win_cnt_q <= '0;
      idle_cnt_q <= '0;
      slip_q <= '0;
      de_q <= 1'b0;
      ctrl_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      prev_word_q <= raw_word;
      sym_q <= sym;
      run_cnt_q <= run_cnt_d;
      win_cnt_q <= win_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      slip_q <= slip_d;
      de_q <= de_d;
      ctrl_q <= ctrl_d;
      data_q <= data_d;
    end
  end

  assign de = de_q;
  assign ctrl = ctrl_q;
  assign data = data_q;
  assign slip_offset = slip_q;

`ifdef TMDS_LOSS_CNT_EN
  logic [15:0] loss_cnt_q, loss_cnt_d;
  assign loss_cnt_d = loss_cnt_q + {15'd0, state_q == LOCKED && state_d == SEARCH && loss_cnt_q != 16'hFFFF};
  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) loss_cnt_q <= '0;
    else loss_cnt_q <= loss_cnt_d;
  end
  assign loss_cnt = loss_cnt_q;
`endif
endmodule

// File: tb/tb_tmds_channel_decoder.sv
// tb_tmds_channel_decoder: directed streams checked every cycle against a bit-queue/lookup-table model.
module tb_tmds_channel_decoder;
  localparam int CTRL_RUN = 8;
  localparam int SEARCH_WINDOW = 64;
  localparam int LOCK_TIMEOUT = 4096;
  localparam logic [9:0] TOK [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

  logic ref_clk = 1'b0, rst_n = 1'b0;
  logic [9:0] raw_word = '0;
  logic de, locked;
  logic [1:0] ctrl;
  logic [7:0] data;
  logic [3:0] slip_offset;
`ifdef TMDS_LOSS_CNT_EN
  logic [15:0] loss_cnt;
`endif

  tmds_channel_decoder dut (
    .ref_clk(ref_clk), .rst_n(rst_n), .raw_word(raw_word), .de(de), .ctrl(ctrl),
    .data(data), .locked(locked), .slip_offset(slip_offset)
`ifdef TMDS_LOSS_CNT_EN
    , .loss_cnt(loss_cnt)
`endif
  );

  always #5 ref_clk = ~ref_clk;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Forward TMDS encoder; bit 0 of the byte picks the output polarity.
  function automatic logic [9:0] enc(input logic [7:0] b);
    logic [8:0] qm;
    int n1;
    logic xn;
    n1 = $countones(b);
    xn = n1 > 4 || (n1 == 4 && !b[0]);
    qm[0] = b[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ b[i]) : qm[i-1] ^ b[i];
    qm[8] = !xn;
    return b[0] ? {1'b1, qm[8], ~qm[7:0]} : {1'b0, qm};
  endfunction

  function automatic int tok_idx(input logic [9:0] s);
    for (int i = 0; i < 4; i++) if (s == TOK[i]) return i;
    return -1;
  endfunction

  // Inverse map built by encoding every byte in both polarities.
  logic [8:0] dec_tab [1024];
  initial begin
    logic [9:0] s;
    for (int i = 0; i < 1024; i++) dec_tab[i] = '0;
    for (int b = 0; b < 256; b++) begin
      s = enc(8'(b));
      dec_tab[s] = {1'b1, 8'(b)};
      s = {~s[9], s[8], ~s[7:0]};
      dec_tab[s] = {1'b1, 8'(b)};
    end
  end

  bit mbits[$];
  int m_off, m_run, m_win, m_idle, m_loss, e_de, e_ctrl, e_data;
  bit m_lk, e_dvalid;
  logic [9:0] m_symq;

  always @(posedge ref_clk or negedge rst_n) begin
    logic [9:0] s;
    int ti;
    if (!rst_n) begin
      mbits = {};
      for (int i = 0; i < 10; i++) mbits.push_back(1'b0);
      m_off = 0; m_run = 0; m_win = 0; m_idle = 0; m_loss = 0; m_lk = 0;
      m_symq = '0; e_de = 0; e_ctrl = 0; e_data = 0; e_dvalid = 1;
    end else begin
      ti = tok_idx(m_symq);
      e_dvalid = 1;
      if (!m_lk) begin
        e_de = 0; e_data = 0; e_ctrl = 0;
      end else if (ti >= 0) begin
        e_de = 0; e_data = 0; e_ctrl = ti;
      end else begin
        e_de = 1; e_dvalid = dec_tab[m_symq][8]; e_data = int'(dec_tab[m_symq][7:0]);
      end
      for (int i = 0; i < 10; i++) mbits.push_back(raw_word[i]);
      for (int i = 0; i < 10; i++) s[i] = mbits[m_off + i];
      repeat (10) void'(mbits.pop_front());
      m_symq = s;
      ti = tok_idx(s);
      if (!m_lk) begin
        m_run = ti >= 0 ? m_run + 1 : 0;
        if (m_run == CTRL_RUN) begin
          m_lk = 1; m_run = 0; m_win = 0; m_idle = 0;
        end else if (m_win == SEARCH_WINDOW - 1) begin
          m_off = (m_off + 1) % 10; m_win = 0; m_run = 0;
        end else m_win++;
      end else begin
        m_idle = ti >= 0 ? 0 : m_idle + 1;
        if (m_idle == LOCK_TIMEOUT) begin
          m_lk = 0; m_idle = 0; m_loss++;
        end
      end
    end
  end

  always @(negedge ref_clk) begin
    if (rst_n) begin
      chk("m_locked", int'(locked), int'(m_lk));
      chk("m_slip", int'(slip_offset), m_off);
      chk("m_de", int'(de), e_de);
      chk("m_ctrl", int'(ctrl), e_ctrl);
      if (e_dvalid) chk("m_data", int'(data), e_data);
`ifdef TMDS_LOSS_CNT_EN
      chk("m_loss", int'(loss_cnt), m_loss);
`endif
    end
  end

  task automatic step(input logic [9:0] w);
    raw_word = w;
    @(posedge ref_clk);
    @(negedge ref_clk);
  endtask

  task automatic do_reset();
    @(negedge ref_clk);
    rst_n = 1'b0;
    raw_word = '0;
    repeat (2) @(negedge ref_clk);
    rst_n = 1'b1;
  endtask

  // Repeated 0x0AB stream delayed by three leading zero bits.
  function automatic logic [9:0] rot_word(input int k);
    logic [9:0] w, tb;
    int p;
    tb = TOK[1];
    for (int i = 0; i < 10; i++) begin
      p = (k - 1) * 10 + i;
      w[i] = p < 3 ? 1'b0 : tb[(p - 3) % 10];
    end
    return w;
  endfunction

  initial begin
    int chg[$];
    int lock_step, prev_slip;
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      step(TOK[0]);
      if (i == 8) chk("t1_prelock", int'(locked), 0);
      if (i == 9) chk("t1_lock", int'(locked), 1);
    end
    chk("t1_slip", int'(slip_offset), 0);
    chk("t1_ctrl", int'(ctrl), 0);
    for (int b = 0; b < 256; b++) begin
      step(enc(8'(b)));
      if (b >= 2) begin
        chk("t1_data", int'(data), b - 2);
        chk("t1_de", int'(de), 1);
      end
    end
    step(TOK[0]);
    chk("t1_data254", int'(data), 254);
    step(TOK[0]);
    chk("t1_data255", int'(data), 255);
    step(TOK[0]);
    chk("t1_de_end", int'(de), 0);
    chk("t1_data_end", int'(data), 0);

    do_reset();
    lock_step = 0;
    prev_slip = 0;
    for (int k = 1; k <= 260; k++) begin
      step(rot_word(k));
      if (int'(slip_offset) != prev_slip) begin
        chg.push_back(k);
        prev_slip = int'(slip_offset);
      end
      if (locked && lock_step == 0) lock_step = k;
    end
    chk("t2_nslips", chg.size(), 3);
    chk("t2_slip1", chg.size() > 0 ? chg[0] : -1, 64);
    chk("t2_slip2", chg.size() > 1 ? chg[1] : -1, 128);
    chk("t2_slip3", chg.size() > 2 ? chg[2] : -1, 192);
    chk("t2_lock_step", lock_step, 200);
    chk("t2_slip", int'(slip_offset), 3);
    chk("t2_ctrl", int'(ctrl), 1);

    do_reset();
    for (int k = 1; k <= 640; k++) begin
      step('0);
      if (k == 575) chk("t3_slip8", int'(slip_offset), 8);
      if (k == 576) chk("t3_slip9", int'(slip_offset), 9);
      if (k == 639) chk("t3_slip9_hold", int'(slip_offset), 9);
      if (k == 640) chk("t3_wrap", int'(slip_offset), 0);
    end
    for (int k = 1; k <= 12; k++) begin
      step(TOK[0]);
      if (k == 8) chk("t3_prelock", int'(locked), 0);
      if (k == 9) chk("t3_lock", int'(locked), 1);
    end
    chk("t3_slip", int'(slip_offset), 0);

    for (int j = 1; j <= 4098; j++) begin
      step(enc(8'(j)));
      if (j == 4096) chk("t4_still_locked", int'(locked), 1);
      if (j == 4097) begin
        chk("t4_drop", int'(locked), 0);
        chk("t4_slip_held", int'(slip_offset), 0);
      end
      if (j == 4098) begin
        chk("t4_de", int'(de), 0);
        chk("t4_data", int'(data), 0);
      end
    end
`ifdef TMDS_LOSS_CNT_EN
    chk("t4_loss", int'(loss_cnt), 1);
`endif

    do_reset();
    repeat (16) step(TOK[0]);
    for (int t = 0; t < 4; t++) begin
      repeat (12) step(TOK[t]);
      chk("t5_ctrl", int'(ctrl), t);
      chk("t5_de", int'(de), 0);
      chk("t5_data", int'(data), 0);
    end

    do_reset();
    repeat (16) step(TOK[3]);
    for (int b = 0; b < 5; b++) step(enc(8'(8'h11 * (b + 1))));
    chk("t6_de_pre", int'(de), 1);
    chk("t6_ctrl_pre", int'(ctrl), 3);
    chk("t6_data_pre", int'(data), 8'h33);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_de", int'(de), 0);
    chk("t6_rst_data", int'(data), 0);
    chk("t6_rst_ctrl", int'(ctrl), 0);
    chk("t6_rst_locked", int'(locked), 0);
    chk("t6_rst_slip", int'(slip_offset), 0);
    repeat (2) @(negedge ref_clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step(TOK[0]);
      if (k == 8) chk("t6_prelock", int'(locked), 0);
      if (k == 9) chk("t6_relock", int'(locked), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
